duty_calc: RTL and testbench
============================

DUTY_CALC -- requirements
Module: duty_calc

Interface
REQ-001 Parameter CNT_W, default 32, width of every incoming count.
REQ-002 Parameter PCT_W, default 7, width of each percentage output.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 red_count  input  CNT_W  running red high-time count from the PWM detector.
REQ-007 green_count  input  CNT_W  running green high-time count.
REQ-008 blue_count  input  CNT_W  running blue high-time count.
REQ-009 total_count  input  CNT_W  running window period count.
REQ-010 red_pct  output  PCT_W  red duty cycle, 0..100.
REQ-011 green_pct  output  PCT_W  green duty cycle, 0..100.
REQ-012 blue_pct  output  PCT_W  blue duty cycle, 0..100.
REQ-013 pct_valid  output  1  one-cycle pulse when all three percentages update together.
REQ-014 busy  output  1  high from capture until the pct_valid cycle, inclusive.
REQ-015 overrun  output  1  sticky flag: a window end was dropped while busy.

Function
REQ-016 The block SHALL register all four inputs every cycle, giving prev_* copies.
REQ-017 Window end is detected when prev_total != 0 and total_count == 0.
REQ-018 On window end while idle, the block SHALL snapshot prev_red, prev_green, prev_blue and prev_total at the same edge (capture edge E).
REQ-019 The FSM states SHALL be IDLE, LOAD, DIV, STORE and DONE.
- IDLE->LOAD on capture.
- LOAD->DIV after 1 cycle.
- DIV->STORE after CNT_W+7 cycles.
- STORE->LOAD for the next channel, or STORE->DONE after blue.
- DONE->IDLE after 1 cycle.
REQ-020 Channels SHALL be processed in the order red, green, blue using one shared divider.
REQ-021 The per-channel dividend SHALL be count*100, CNT_W+7 bits wide, with no truncation.
REQ-022 The divisor SHALL be the snapshot total.
REQ-023 The quotient SHALL be floor(count*100/total), computed by restoring division at one bit per cycle.
REQ-024 The percentage outputs SHALL update only together, in the DONE cycle, with pct_valid high in that cycle only.
REQ-025 pct_valid SHALL assert exactly at edge E+124 (for CNT_W=32).
REQ-026 The outputs SHALL hold their values until the next DONE.
REQ-027 If the snapshot total equals 0, all three percentages SHALL be 0, with the same latency.
REQ-028 If a channel count exceeds the total, that percentage SHALL clamp to 100.
REQ-029 A window end while busy SHALL be ignored and SHALL set overrun, which is cleared only by reset.
REQ-030 Input changes during DIV SHALL NOT affect results, because only the snapshot is used.

Reset
REQ-031 While rst is low, all outputs SHALL be 0 and the FSM SHALL be in IDLE, regardless of the clock.
REQ-032 Reset asserted mid-operation SHALL abort the computation without a pct_valid pulse.
REQ-033 After reset release, the first window end SHALL require prev_total != 0, so a zero count at start-up is not a false capture.

Structure
REQ-034 A shared package SHALL hold CNT_W, PCT_W, PCT_MAX=100, DIV_CYCLES=CNT_W+7 and the FSM state enum.
REQ-035 The divider SHALL be a sub-module seq_div.
- Ports: start, dividend, divisor, quotient, done.
- Iterative, one quotient bit per cycle.
REQ-036 The top-level SHALL contain the edge detection, snapshot, channel sequencer and clamp.

Verification
REQ-037 red=0x480000, total=0x900000, then total->0: red_pct=50 and pct_valid pulses at E+124.
REQ-038 Snapshot total=0 (counts nonzero): all percentages 0, pct_valid still pulses.
REQ-039 green=0x900005, total=0x900000: green_pct=100 (clamped).
REQ-040 blue=0x8FFFFF, total=0x900000: blue_pct=99 (floor, no rounding).
REQ-041 A second window end at E+60: ignored, overrun=1, first-window results are reported.
REQ-042 rst low at E+50 for 2 cycles: outputs 0, busy 0, no pct_valid; the next window end computes normally.

Source files
------------

// File: rtl/duty_calc_pkg.sv
// Shared widths, constants and state types for the RGB duty-cycle calculator.
package duty_calc_pkg;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned PCT_W      = 7;
    localparam int unsigned PCT_MAX    = 100;
    localparam int unsigned DIV_CYCLES = CNT_W + 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CH_RED,
        CH_GREEN,
        CH_BLUE
    } chan_t;

endpackage

// File: rtl/duty_calc_if.sv
// Count inputs from the PWM detector and the percentage results of duty_calc.
interface duty_calc_if #(
    parameter int unsigned CNT_W = duty_calc_pkg::CNT_W,
    parameter int unsigned PCT_W = duty_calc_pkg::PCT_W
);

    logic [CNT_W-1:0] red_count;
    logic [CNT_W-1:0] green_count;
    logic [CNT_W-1:0] blue_count;
    logic [CNT_W-1:0] total_count;

    logic [PCT_W-1:0] red_pct;
    logic [PCT_W-1:0] green_pct;
    logic [PCT_W-1:0] blue_pct;
    logic             pct_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output red_count, green_count, blue_count, total_count,
        input  red_pct, green_pct, blue_pct, pct_valid, busy, overrun
    );

    modport slave (
        input  red_count, green_count, blue_count, total_count,
        output red_pct, green_pct, blue_pct, pct_valid, busy, overrun
    );

endinterface

// File: rtl/duty_calc_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so DVD_W cycles later the quotient is final.
module seq_div #(
    parameter int unsigned DVD_W = 39,
    parameter int unsigned DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    localparam int unsigned CW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q;
    logic [DVD_W-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic [DVS_W-1:0] rem_src_c;
    logic [DVD_W-1:0] quo_src_c;
    logic [DVS_W:0]   rem_shift_c;
    logic [DVS_W-1:0] diff_c;
    logic             q_bit_c;
    logic [DVS_W-1:0] rem_nxt_c;
    logic [DVD_W-1:0] quo_nxt_c;

    // One restoring step; a start restarts from a zero remainder.
    always_comb begin
        rem_src_c   = start ? '0 : rem_q;
        quo_src_c   = start ? dividend : quo_q;
        rem_shift_c = {rem_src_c, quo_src_c[DVD_W-1]};
        diff_c      = rem_shift_c[DVS_W-1:0] - divisor;
        q_bit_c     = (rem_shift_c >= {1'b0, divisor});
        rem_nxt_c   = q_bit_c ? diff_c : rem_shift_c[DVS_W-1:0];
        quo_nxt_c   = {quo_src_c[DVD_W-2:0], q_bit_c};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_nxt_c;
            quo_q  <= quo_nxt_c;
            cnt_q  <= CW'(DVD_W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= rem_nxt_c;
            quo_q  <= quo_nxt_c;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/duty_calc.sv
// Converts PWM high-time counts into red/green/blue duty percentages at each
// measurement window end, sharing one sequential divider across channels.
module duty_calc
    import duty_calc_pkg::*;
#(
    parameter int unsigned CNT_W = duty_calc_pkg::CNT_W,
    parameter int unsigned PCT_W = duty_calc_pkg::PCT_W
) (
    input  logic        clk,
    input  logic        rst,
    duty_calc_if.slave  bus
);

    localparam int unsigned DIV_W = CNT_W + 7;

    logic [CNT_W-1:0] prev_red, prev_green, prev_blue, prev_total;
    logic [CNT_W-1:0] snap_red, snap_green, snap_blue, snap_total;

    state_t state, state_nxt;
    chan_t  chan;

    logic [PCT_W-1:0] res_red, res_green, res_blue;
    logic [PCT_W-1:0] red_pct_q, green_pct_q, blue_pct_q;
    logic             pct_valid_q, busy_q, overrun_q;

    logic             win_end_c, capture_c;
    logic             div_start_c, store_c, publish_c;
    logic [CNT_W-1:0] cnt_sel_c;
    logic [DIV_W-1:0] dividend_c;
    logic [DIV_W-1:0] quotient;
    logic             div_done;
    logic [PCT_W-1:0] pct_c;

    // A window ends when the running period count falls from nonzero to zero.
    assign win_end_c = (prev_total != '0) && (bus.total_count == '0);
    assign capture_c = win_end_c && !busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (capture_c) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_DIV;
            ST_DIV:   if (div_done) state_nxt = ST_STORE;
            ST_STORE: state_nxt = (chan == CH_BLUE) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start_c = 1'b0;
        store_c     = 1'b0;
        publish_c   = 1'b0;
        case (state)
            ST_LOAD:  div_start_c = 1'b1;
            ST_STORE: store_c     = 1'b1;
            ST_DONE:  publish_c   = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        case (chan)
            CH_RED:   cnt_sel_c = snap_red;
            CH_GREEN: cnt_sel_c = snap_green;
            CH_BLUE:  cnt_sel_c = snap_blue;
            default:  cnt_sel_c = snap_red;
        endcase
    end

    // count*100 needs 7 extra bits so nothing is lost before the divide.
    assign dividend_c = DIV_W'(cnt_sel_c) * DIV_W'(PCT_MAX);

    seq_div #(
        .DVD_W (DIV_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (dividend_c),
        .divisor  (snap_total),
        .quotient (quotient),
        .done     (div_done)
    );

    // Zero period reports 0; counts above the period saturate at 100.
    always_comb begin
        if (snap_total == '0)
            pct_c = '0;
        else if (quotient > DIV_W'(PCT_MAX))
            pct_c = PCT_W'(PCT_MAX);
        else
            pct_c = PCT_W'(quotient);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_red   <= '0;
            prev_green <= '0;
            prev_blue  <= '0;
            prev_total <= '0;
            snap_red   <= '0;
            snap_green <= '0;
            snap_blue  <= '0;
            snap_total <= '0;
        end else begin
            prev_red   <= bus.red_count;
            prev_green <= bus.green_count;
            prev_blue  <= bus.blue_count;
            prev_total <= bus.total_count;
            if (capture_c) begin
                snap_red   <= prev_red;
                snap_green <= prev_green;
                snap_blue  <= prev_blue;
                snap_total <= prev_total;
            end
        end
    end

    // Channel sequencer and per-channel result holding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan      <= CH_RED;
            res_red   <= '0;
            res_green <= '0;
            res_blue  <= '0;
        end else if (capture_c) begin
            chan <= CH_RED;
        end else if (store_c) begin
            case (chan)
                CH_RED: begin
                    res_red <= pct_c;
                    chan    <= CH_GREEN;
                end
                CH_GREEN: begin
                    res_green <= pct_c;
                    chan      <= CH_BLUE;
                end
                default: begin
                    res_blue <= pct_c;
                    chan     <= CH_RED;
                end
            endcase
        end
    end

    // Results publish together; busy spans capture through the valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_pct_q   <= '0;
            green_pct_q <= '0;
            blue_pct_q  <= '0;
            pct_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pct_valid_q <= publish_c;
            if (publish_c) begin
                red_pct_q   <= res_red;
                green_pct_q <= res_green;
                blue_pct_q  <= res_blue;
            end
            if (capture_c)
                busy_q <= 1'b1;
            else if (pct_valid_q)
                busy_q <= 1'b0;
            if (win_end_c && busy_q)
                overrun_q <= 1'b1;
        end
    end

    assign bus.red_pct   = red_pct_q;
    assign bus.green_pct = green_pct_q;
    assign bus.blue_pct  = blue_pct_q;
    assign bus.pct_valid = pct_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_duty_calc.sv
// Self-checking bench for duty_calc: directed vector table, random windows
// against an arithmetic reference, plus overrun and mid-operation reset cases.
module tb_duty_calc;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned PCT_W   = 7;
    localparam int unsigned LATENCY = 124;

    typedef struct {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
        logic [31:0] t;
        int          er;
        int          eg;
        int          eb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    duty_calc_if #(.CNT_W(CNT_W), .PCT_W(PCT_W)) bus ();

    duty_calc #(.CNT_W(CNT_W), .PCT_W(PCT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic longint unsigned ref_pct(longint unsigned c, longint unsigned t);
        longint unsigned q;
        if (t == 0) return 0;
        q = (c * 100) / t;
        return (q > 100) ? 100 : q;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Unrelated input activity that never forms a window end.
    task automatic noise();
        bus.red_count   = $urandom;
        bus.green_count = $urandom;
        bus.blue_count  = $urandom;
        bus.total_count = $urandom | 32'h1;
    endtask

    task automatic start_window(input logic [31:0] r, input logic [31:0] g,
                                input logic [31:0] b, input logic [31:0] t,
                                output int unsigned e);
        bus.red_count   = r;
        bus.green_count = g;
        bus.blue_count  = b;
        bus.total_count = t;
        step();
        bus.total_count = '0;
        step();
        e = cyc;
        check("busy_at_capture", bus.busy, 1);
    endtask

    task automatic finish_window(input string tag, input int unsigned e,
                                 input int er, input int eg, input int eb, input bit ovr);
        int n = 0;
        while (!bus.pct_valid && n < 300) begin
            noise();
            step();
            n++;
        end
        check({tag, "_latency"}, cyc - e, LATENCY);
        check({tag, "_red"}, bus.red_pct, er);
        check({tag, "_green"}, bus.green_pct, eg);
        check({tag, "_blue"}, bus.blue_pct, eb);
        check({tag, "_busy_on_valid"}, bus.busy, 1);
        check({tag, "_overrun"}, bus.overrun, ovr);
        noise();
        step();
        check({tag, "_valid_one_cycle"}, bus.pct_valid, 0);
        check({tag, "_red_hold"}, bus.red_pct, er);
        check({tag, "_busy_cleared"}, bus.busy, 0);
    endtask

    initial begin
        int unsigned     e;
        int              pulses;
        logic [31:0]     r, g, b, t;
        longint unsigned lim;

        vecs[0] = '{32'h0048_0000, 32'h0090_0005, 32'h008F_FFFF, 32'h0090_0000, 50, 100, 99};
        vecs[1] = '{32'd0, 32'd0, 32'd0, 32'd100, 0, 0, 0};
        vecs[2] = '{32'd1, 32'd2, 32'd3, 32'd3, 33, 66, 100};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 100, 100, 0};
        vecs[4] = '{32'd1, 32'hFFFF_FFFF, 32'd5, 32'd1, 100, 100, 100};
        vecs[5] = '{32'd7, 32'd13, 32'd199, 32'd200, 3, 6, 99};
        vecs[6] = '{32'd10, 32'd1, 32'd19, 32'd20, 50, 5, 95};

        rst = 1'b0;
        bus.red_count   = '0;
        bus.green_count = '0;
        bus.blue_count  = '0;
        bus.total_count = '0;
        step();
        step();
        check("reset_red_pct", bus.red_pct, 0);
        check("reset_pct_valid", bus.pct_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_overrun", bus.overrun, 0);

        // Zero period count straight out of reset must not look like a window end.
        rst = 1'b1;
        repeat (3) step();
        check("no_false_capture", bus.busy, 0);

        for (int i = 0; i < 7; i++) begin
            start_window(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].t, e);
            finish_window($sformatf("vec%0d", i), e, vecs[i].er, vecs[i].eg, vecs[i].eb, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            t = $urandom >> $urandom_range(0, 31);
            if (t == 0) t = 1;
            lim = longint'(t) + longint'(t) / 8 + 1;
            r = 32'(longint'($urandom) % lim);
            g = 32'(longint'($urandom) % lim);
            b = 32'(longint'($urandom) % lim);
            start_window(r, g, b, t, e);
            finish_window($sformatf("rand%0d", i), e, int'(ref_pct(r, t)),
                          int'(ref_pct(g, t)), int'(ref_pct(b, t)), 1'b0);
        end

        // Second window end while the first is still being divided.
        start_window(vecs[0].r, vecs[0].g, vecs[0].b, vecs[0].t, e);
        while (cyc != e + 59) begin
            noise();
            step();
        end
        bus.total_count = '0;
        step();
        check("overrun_set", bus.overrun, 1);
        finish_window("ovr", e, 50, 100, 99, 1'b1);

        start_window(vecs[2].r, vecs[2].g, vecs[2].b, vecs[2].t, e);
        finish_window("sticky", e, 33, 66, 100, 1'b1);

        // Reset in the middle of a computation.
        start_window(vecs[6].r, vecs[6].g, vecs[6].b, vecs[6].t, e);
        while (cyc != e + 49) begin
            noise();
            step();
        end
        rst = 1'b0;
        #1;
        check("abort_red_pct", bus.red_pct, 0);
        check("abort_green_pct", bus.green_pct, 0);
        check("abort_blue_pct", bus.blue_pct, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_overrun", bus.overrun, 0);
        step();
        step();
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 140; k++) begin
            noise();
            step();
            if (bus.pct_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_idle_busy", bus.busy, 0);

        start_window(vecs[5].r, vecs[5].g, vecs[5].b, vecs[5].t, e);
        finish_window("post_reset", e, 3, 6, 99, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
